// File: rtl/crossbar_pkg.sv
// Shared crossbar types: channel selectors, port maps, controller FSM states.
// No logic state of its own; imported by the input- and output-side controllers.
package crossbar_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] sel_t;
    typedef sel_t [NUM_PORTS-1:0] map_t;

    localparam map_t XBAR_IDENTITY = {2'd3, 2'd2, 2'd1, 2'd0};

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    // A map is usable only if every port draws from a different channel.
    function automatic logic is_permutation(input map_t m);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = i + 1; j < NUM_PORTS; j++) begin
                if (m[i] == m[j]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/crossbar_switch_out_ctl_if.sv
// Config handshake, frame sync, channel inputs and port outputs of the output crossbar.
// slave = controller side, master = driver/observer side.
interface crossbar_switch_out_ctl_if #(
    parameter int IO_WIDTH = 1
);
    logic                cfg_valid_in;
    logic                cfg_ready_out;
    logic [1:0]          cfg_sel_a_in;
    logic [1:0]          cfg_sel_b_in;
    logic [1:0]          cfg_sel_c_in;
    logic [1:0]          cfg_sel_d_in;
    logic                cfg_err_out;
    logic                frame_sync_in;
    logic [IO_WIDTH-1:0] chan_a_in;
    logic [IO_WIDTH-1:0] chan_b_in;
    logic [IO_WIDTH-1:0] chan_c_in;
    logic [IO_WIDTH-1:0] chan_d_in;
    logic [IO_WIDTH-1:0] port_a_out;
    logic [IO_WIDTH-1:0] port_b_out;
    logic [IO_WIDTH-1:0] port_c_out;
    logic [IO_WIDTH-1:0] port_d_out;
    logic                port_valid_out;

    modport slave (
        input  cfg_valid_in, cfg_sel_a_in, cfg_sel_b_in, cfg_sel_c_in, cfg_sel_d_in,
        input  frame_sync_in, chan_a_in, chan_b_in, chan_c_in, chan_d_in,
        output cfg_ready_out, cfg_err_out,
        output port_a_out, port_b_out, port_c_out, port_d_out, port_valid_out
    );

    modport master (
        output cfg_valid_in, cfg_sel_a_in, cfg_sel_b_in, cfg_sel_c_in, cfg_sel_d_in,
        output frame_sync_in, chan_a_in, chan_b_in, chan_c_in, chan_d_in,
        input  cfg_ready_out, cfg_err_out,
        input  port_a_out, port_b_out, port_c_out, port_d_out, port_valid_out
    );
endinterface

// File: rtl/crossbar_out_mux.sv
// 4:1 channel selector for one output port.
// Latency: combinational. Backpressure: none.
module crossbar_out_mux
    import crossbar_pkg::*;
#(
    parameter int IO_WIDTH = 1
) (
    input  logic [IO_WIDTH-1:0] chan_a,
    input  logic [IO_WIDTH-1:0] chan_b,
    input  logic [IO_WIDTH-1:0] chan_c,
    input  logic [IO_WIDTH-1:0] chan_d,
    input  sel_t                sel,
    output logic [IO_WIDTH-1:0] y
);
    always_comb begin
        y = chan_a;
        case (sel)
            2'd0:    y = chan_a;
            2'd1:    y = chan_b;
            2'd2:    y = chan_c;
            default: y = chan_d;
        endcase
    end
endmodule

// File: rtl/crossbar_switch_out_ctl.sv
// Routes four channel buffers onto four output ports; new maps switch in only at a frame boundary, then blank.
// Latency: 1 cycle chan->port. Backpressure: cfg_ready_out low from map acceptance until blanking ends.
module crossbar_switch_out_ctl
    import crossbar_pkg::*;
#(
    parameter int IO_WIDTH     = 1,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    crossbar_switch_out_ctl_if.slave  io
);
    localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    state_t               state, state_nxt;
    map_t                 active_map, shadow_map, map_eff, cfg_map;
    logic [CNT_W-1:0]     blank_cnt;
    logic                 cfg_fire, cfg_ok, switch_now, blank_done;
    logic [IO_WIDTH-1:0]  mux_y [NUM_PORTS];

    assign cfg_map    = {io.cfg_sel_d_in, io.cfg_sel_c_in, io.cfg_sel_b_in, io.cfg_sel_a_in};
    assign cfg_fire   = io.cfg_valid_in && io.cfg_ready_out;
    assign cfg_ok     = is_permutation(cfg_map);
    assign switch_now = (state == ST_PENDING) && io.frame_sync_in;
    assign blank_done = (blank_cnt == CNT_W'(BLANK_CYCLES));
    // The frame-boundary cycle already samples under the new map so BLANK_CYCLES=0 has no gap.
    assign map_eff    = switch_now ? shadow_map : active_map;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE:  if (cfg_fire && cfg_ok) state_nxt = ST_PENDING;
            ST_PENDING: if (io.frame_sync_in)
                            state_nxt = (BLANK_CYCLES == 0) ? ST_ACTIVE : ST_BLANK;
            ST_BLANK:   if (blank_done) state_nxt = ST_ACTIVE;
            default:    state_nxt = ST_ACTIVE;
        endcase
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_mux
        crossbar_out_mux #(.IO_WIDTH(IO_WIDTH)) u_mux (
            .chan_a (io.chan_a_in),
            .chan_b (io.chan_b_in),
            .chan_c (io.chan_c_in),
            .chan_d (io.chan_d_in),
            .sel    (map_eff[p]),
            .y      (mux_y[p])
        );
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= ST_ACTIVE;
            active_map        <= XBAR_IDENTITY;
            shadow_map        <= XBAR_IDENTITY;
            blank_cnt         <= '0;
            io.cfg_ready_out  <= 1'b0;
            io.cfg_err_out    <= 1'b0;
            io.port_valid_out <= 1'b0;
            io.port_a_out     <= '0;
            io.port_b_out     <= '0;
            io.port_c_out     <= '0;
            io.port_d_out     <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_fire && cfg_ok) shadow_map <= cfg_map;
            if (switch_now)         active_map <= shadow_map;
            if (state_nxt == ST_BLANK)
                blank_cnt <= (state == ST_BLANK) ? blank_cnt + CNT_W'(1) : CNT_W'(1);
            else
                blank_cnt <= '0;
            io.cfg_ready_out  <= (state_nxt == ST_ACTIVE);
            io.cfg_err_out    <= cfg_fire && !cfg_ok;
            io.port_valid_out <= (state_nxt != ST_BLANK);
            if (state_nxt == ST_BLANK) begin
                io.port_a_out <= '0;
                io.port_b_out <= '0;
                io.port_c_out <= '0;
                io.port_d_out <= '0;
            end else begin
                io.port_a_out <= mux_y[0];
                io.port_b_out <= mux_y[1];
                io.port_c_out <= mux_y[2];
                io.port_d_out <= mux_y[3];
            end
        end
    end
endmodule
